// File: rtl/note_cmd_rx.sv
// MIDI-rate UART receiver plus 3-byte note-packet parser.
// Holds per-channel note, enable and FX-select registers for the synth channels.
module note_cmd_rx #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [23:0] note_out,
  output logic [3:0]  en_out,
  output logic [7:0]  fx_out,
  output logic        cmd_valid,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rstate_t;
  typedef enum logic [1:0] {P_STATUS, P_NOTE, P_FX} pstate_t;

  rstate_t            rstate;
  pstate_t            pstate;
  logic               rx_s1, rx_s2;
  logic [CW-1:0]      cnt;
  logic [2:0]         bitn;
  logic [7:0]         shreg;
  logic               p_on;
  logic [1:0]         p_ch;
  logic [5:0]         p_note;
  logic [3:0][5:0]    note_r;
  logic [3:0][1:0]    fx_r;
  logic [3:0]         en_r;

  assign note_out = note_r;
  assign fx_out   = fx_r;
  assign en_out   = en_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      pstate    <= P_STATUS;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      p_on      <= 1'b0;
      p_ch      <= '0;
      p_note    <= '0;
      note_r    <= '0;
      fx_r      <= '0;
      en_r      <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      case (rstate)
        R_IDLE: begin
          cnt <= '0;
          // R_WAIT guarantees the line was high before we got here
          if (!rx_s2) rstate <= R_START;
        end
        R_START: begin
          if (cnt == HALF) begin
            cnt    <= '0;
            bitn   <= '0;
            rstate <= rx_s2 ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        end
        R_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) rstate <= R_STOP;
          end else cnt <= cnt + 1'b1;
        end
        R_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (!rx_s2) begin
              frame_err <= 1'b1;
              pstate    <= P_STATUS;
              rstate    <= R_WAIT;
            end else begin
              rstate <= R_IDLE;
              // Byte accepted: status bytes always restart the parser
              if (shreg[7]) begin
                if (shreg[7:5] == 3'b100) begin
                  p_on   <= shreg[4];
                  p_ch   <= shreg[1:0];
                  pstate <= P_NOTE;
                end else pstate <= P_STATUS;
              end else begin
                case (pstate)
                  P_NOTE: begin
                    p_note <= shreg[6] ? 6'd63 : shreg[5:0];
                    pstate <= P_FX;
                  end
                  P_FX: begin
                    if (p_on) begin
                      fx_r[p_ch] <= shreg[1:0];
                      if (p_note != 6'd0) begin
                        note_r[p_ch] <= p_note;
                        en_r[p_ch]   <= 1'b1;
                      end else begin
                        note_r[p_ch] <= 6'd0;
                        en_r[p_ch]   <= 1'b0;
                      end
                    end else if (note_r[p_ch] == p_note) begin
                      en_r[p_ch] <= 1'b0;
                    end
                    cmd_valid <= 1'b1;
                    pstate    <= P_STATUS;
                  end
                  default: pstate <= P_STATUS;
                endcase
              end
            end
          end else cnt <= cnt + 1'b1;
        end
        R_WAIT: if (rx_s2) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_cmd_rx.sv
// Directed bench for note_cmd_rx at 16 clocks per bit.
module tb_note_cmd_rx;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [23:0] note_out;
  logic [3:0]  en_out;
  logic [7:0]  fx_out;
  logic        cmd_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int ncmd = 0;
  int nfe = 0;

  note_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .note_out(note_out), .en_out(en_out),
    .fx_out(fx_out), .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) ncmd++;
      if (frame_err) nfe++;
      if (cmd_valid && frame_err) begin
        checks++; errors++;
        $display("FAIL excl: cmd_valid and frame_err both high");
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wait_clks(CPB); end
    rx = 1'b1; wait_clks(CPB);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c); wait_clks(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(1000);
    checks++;
    if (note_out !== 24'h0 || en_out !== 4'h0 || fx_out !== 8'h0) begin
      errors++; $display("FAIL reset_outs: note=%h en=%b fx=%h, want 0", note_out, en_out, fx_out);
    end
    checks++;
    if (ncmd !== 0 || nfe !== 0) begin
      errors++; $display("FAIL reset_pulses: cmd=%0d fe=%0d, want 0", ncmd, nfe);
    end
  endtask

  task automatic test_note_on;
    int c0;
    c0 = ncmd;
    send_pkt(8'h91, 8'h29, 8'h01);
    checks++;
    if (note_out !== 24'h000A40 || en_out !== 4'b0010 || fx_out !== 8'h04) begin
      errors++; $display("FAIL note_on: note=%h en=%b fx=%h, want 000a40 0010 04", note_out, en_out, fx_out);
    end
    checks++;
    if (ncmd - c0 !== 1) begin
      errors++; $display("FAIL note_on_cmd: pulses=%0d, want 1", ncmd - c0);
    end
  endtask

  task automatic test_note_off;
    int c0;
    c0 = ncmd;
    send_pkt(8'h81, 8'h0D, 8'h00);
    checks++;
    if (en_out !== 4'b0010 || note_out !== 24'h000A40) begin
      errors++; $display("FAIL off_mismatch: note=%h en=%b, want 000a40 0010", note_out, en_out);
    end
    send_pkt(8'h81, 8'h29, 8'h00);
    checks++;
    if (en_out !== 4'b0000 || note_out !== 24'h000A40 || fx_out !== 8'h04) begin
      errors++; $display("FAIL off_match: note=%h en=%b fx=%h, want 000a40 0000 04", note_out, en_out, fx_out);
    end
    checks++;
    if (ncmd - c0 !== 2) begin
      errors++; $display("FAIL off_cmd: pulses=%0d, want 2", ncmd - c0);
    end
  endtask

  task automatic test_clamp;
    send_pkt(8'h92, 8'h50, 8'h03);
    checks++;
    if (note_out !== 24'h03FA40 || en_out !== 4'b0100 || fx_out !== 8'h34) begin
      errors++; $display("FAIL clamp: note=%h en=%b fx=%h, want 03fa40 0100 34", note_out, en_out, fx_out);
    end
  endtask

  task automatic test_abort;
    int c0;
    c0 = ncmd;
    send_byte(8'h90); send_byte(8'h10);
    send_pkt(8'h93, 8'h05, 8'h02);
    checks++;
    if (note_out !== 24'h17FA40 || en_out !== 4'b1100 || fx_out !== 8'hB4) begin
      errors++; $display("FAIL abort: note=%h en=%b fx=%h, want 17fa40 1100 b4", note_out, en_out, fx_out);
    end
    checks++;
    if (ncmd - c0 !== 1) begin
      errors++; $display("FAIL abort_cmd: pulses=%0d, want 1", ncmd - c0);
    end
  endtask

  task automatic test_break;
    int c0, f0;
    c0 = ncmd; f0 = nfe;
    rx = 1'b0; wait_clks(20 * CPB);
    rx = 1'b1; wait_clks(2 * CPB);
    checks++;
    if (nfe - f0 !== 1 || ncmd - c0 !== 0) begin
      errors++; $display("FAIL break_fe: fe=%0d cmd=%0d, want 1 0", nfe - f0, ncmd - c0);
    end
    send_pkt(8'h90, 8'h07, 8'h00);
    checks++;
    if (note_out !== 24'h17FA47 || en_out !== 4'b1101 || fx_out !== 8'hB4) begin
      errors++; $display("FAIL break_pkt: note=%h en=%b fx=%h, want 17fa47 1101 b4", note_out, en_out, fx_out);
    end
    checks++;
    if (nfe - f0 !== 1 || ncmd - c0 !== 1) begin
      errors++; $display("FAIL break_cnt: fe=%0d cmd=%0d, want 1 1", nfe - f0, ncmd - c0);
    end
  endtask

  // A glitch accepted as a byte in the FX slot would complete the packet early
  task automatic test_glitch;
    int c0, f0;
    c0 = ncmd; f0 = nfe;
    send_byte(8'h90); send_byte(8'h08);
    rx = 1'b0; wait_clks(4);
    rx = 1'b1; wait_clks(12 * CPB);
    checks++;
    if (ncmd - c0 !== 0 || nfe - f0 !== 0) begin
      errors++; $display("FAIL glitch_rx: cmd=%0d fe=%0d, want 0 0", ncmd - c0, nfe - f0);
    end
    send_byte(8'h02); wait_clks(4);
    checks++;
    if (note_out !== 24'h17FA48 || fx_out !== 8'hB6 || ncmd - c0 !== 1) begin
      errors++; $display("FAIL glitch_pkt: note=%h fx=%h cmd=%0d, want 17fa48 b6 1", note_out, fx_out, ncmd - c0);
    end
  endtask

  task automatic test_note_zero;
    send_pkt(8'h93, 8'h00, 8'h01);
    checks++;
    if (note_out !== 24'h03FA48 || en_out !== 4'b0101 || fx_out !== 8'h76) begin
      errors++; $display("FAIL note_zero: note=%h en=%b fx=%h, want 03fa48 0101 76", note_out, en_out, fx_out);
    end
  endtask

  task automatic test_async_reset;
    int c0;
    send_byte(8'h91); send_byte(8'h20);
    rx = 1'b0; wait_clks(3 * CPB);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (note_out !== 24'h0 || en_out !== 4'h0 || fx_out !== 8'h0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst: note=%h en=%b fx=%h, want 0", note_out, en_out, fx_out);
    end
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * CPB);
    c0 = ncmd;
    send_byte(8'h01); wait_clks(4);
    checks++;
    if (ncmd - c0 !== 0) begin
      errors++; $display("FAIL rst_drop: cmd=%0d, want 0", ncmd - c0);
    end
    send_pkt(8'h92, 8'h11, 8'h01);
    checks++;
    if (note_out !== 24'h011000 || en_out !== 4'b0100 || fx_out !== 8'h10 || ncmd - c0 !== 1) begin
      errors++; $display("FAIL rst_recover: note=%h en=%b fx=%h cmd=%0d, want 011000 0100 10 1",
                         note_out, en_out, fx_out, ncmd - c0);
    end
  endtask

  initial begin
    test_reset;
    test_note_on;
    test_note_off;
    test_clamp;
    test_abort;
    test_break;
    test_glitch;
    test_note_zero;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
